rtc_hms_alarm: RTL
==================

# rtc_hms_alarm

Parametrised real-time clock keeping hours, minutes and seconds from a configurable system-clock prescaler, with validated time load, run/hold control, a 12-hour display view and a single hh:mm alarm with sticky interrupt. It sits between the system clock domain and the display/control logic, replacing the fixed-ratio minute counter with a full hh:mm:ss timebase.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second; legal range ≥ 2.
- `PRESC_W`, default 26: prescaler width; must satisfy 2^PRESC_W ≥ TICKS_PER_SEC.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: 1 = prescaler advances; 0 = prescaler and time frozen.
- `load_valid` in 1: load request, single-cycle qualifier.
- `load_hh` in 5, `load_mm` in 6, `load_ss` in 6: load values.
- `load_err` out 1: one-cycle pulse, load rejected.
- `alarm_en` in 1: enables alarm match.
- `alarm_hh` in 5, `alarm_mm` in 6: alarm time.
- `alarm_ack` in 1: clears pending alarm.
- `alarm_irq` out 1: sticky alarm pending.
- `hh` out 5, `mm` out 6, `ss` out 6: current time, 24-hour.
- `hh12` out 4, `pm` out 1: 12-hour view of `hh`.
- `sec_tick` out 1: one-cycle pulse on each second advance.
- `day_tick` out 1: one-cycle pulse on 23:59:59 → 00:00:00.

## Operation
- Prescaler counts 0..TICKS_PER_SEC-1 while `run`=1. Internal tick is asserted when count == TICKS_PER_SEC-1 and `run`=1; the count then wraps to 0.
- On a tick, ss increments.
  - ss 59 → 0 carries into mm.
  - mm 59 → 0 carries into hh.
  - hh 23 → 0 asserts `day_tick`.
- Load:
  - When `load_valid`=1 and load_hh ≤ 23, load_mm ≤ 59, load_ss ≤ 59, the time registers take the load values and the prescaler clears to 0.
  - If any field is out of range, time and prescaler are unchanged and `load_err` pulses.
  - Load has priority over a coincident tick; that tick is discarded and `sec_tick` stays 0.
  - Load works regardless of `run`.
- Alarm:
  - A match is a tick-driven transition into hh=alarm_hh, mm=alarm_mm, ss=0 with `alarm_en`=1.
  - A load never raises a match, even if it loads the alarm time.
  - On a match, `alarm_irq` sets. It stays set until a cycle with `alarm_ack`=1 and no new match.
  - Match and ack in the same cycle: set wins.
  - Deasserting `alarm_en` does not clear a pending irq.
  - An out-of-range alarm_hh/alarm_mm never matches.
- 12-hour view, combinational from `hh`:
  - hh=0 → hh12=12; 1..12 → hh12=hh; 13..23 → hh12=hh-12.
  - pm = (hh ≥ 12).
- Arithmetic: all compares are unsigned at field width; no field ever holds an out-of-range value.

## Timing
- Reset values: hh=mm=ss=0, prescaler=0, `sec_tick`=0, `day_tick`=0, `alarm_irq`=0, `load_err`=0. `hh12`=12 and `pm`=0 follow from hh=0.
- First tick after reset (with `run`=1 throughout) occurs at the TICKS_PER_SEC-th rising edge after `rst` deasserts.
  - hh/mm/ss, `sec_tick`, `day_tick` and `alarm_irq` all update on that same edge, i.e. they are registered outputs.
- Load: new time is visible the cycle after `load_valid`. The next tick follows a full TICKS_PER_SEC cycles later. `load_err` is visible the cycle after the request.
- `run` low for N cycles delays all subsequent ticks by exactly N cycles; the prescaler value is preserved.
- `rst` asserted mid-count or mid-alarm returns every register to its reset value on the next edge.
- Back-to-back `load_valid` cycles are each evaluated independently; the last legal one wins.

## Structure
- Shared package `rtc_pkg`:
  - constants HH_W=5, MS_W=6, MAX_HH=23, MAX_MS=59;
  - a time record type {hh, mm, ss};
  - a `time_legal` check function, reused by load and alarm validation.
- Sub-module `rtc_prescaler` (parameters TICKS_PER_SEC, PRESC_W; inputs clk, rst, run, clear; output tick).
- The top level holds the time counters, load validation, alarm logic and the 12-hour mapping.

## Test plan
All scenarios use TICKS_PER_SEC=4.
1. Reset, `run`=1, 16 cycles → `sec_tick` pulses at cycles 4, 8, 12, 16; ss=4; hh12=12, pm=0.
2. Load 23:59:58, run 8 cycles → 23:59:59, then 00:00:00 with `day_tick`=1 for exactly one cycle.
3. Load 24:00:00, then separately 12:60:00 → each rejected, `load_err` one-cycle pulse, time unchanged. Load 13:05:00 → hh12=1, pm=1.
4. Alarm 07:30 with `alarm_en`=1, load 07:29:59, one tick → `alarm_irq`=1. Ack with no match → 0. Reload 07:30:00 directly → no irq.
5. `load_valid` on the tick cycle → loaded value appears, no `sec_tick`, next tick 4 cycles later. `run`=0 for 10 cycles mid-count → tick delayed by 10.
6. Pending alarm plus `rst` mid-second → all outputs at reset values next cycle; first tick 4 cycles after release.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared field widths, limits and time record for the hh:mm:ss real-time clock.
package rtc_pkg;
    localparam int HH_W = 5;
    localparam int MS_W = 6;
    localparam logic [HH_W-1:0] MAX_HH = 5'd23;
    localparam logic [MS_W-1:0] MAX_MS = 6'd59;

    typedef struct packed {
        logic [HH_W-1:0] hh;
        logic [MS_W-1:0] mm;
        logic [MS_W-1:0] ss;
    } rtc_time_t;

    function automatic logic time_legal(input rtc_time_t t);
        return (t.hh <= MAX_HH) && (t.mm <= MAX_MS) && (t.ss <= MAX_MS);
    endfunction
endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC running cycles.
module rtc_prescaler #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PRESC_W       = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (tick)    count <= '0;
        else if (run)     count <= count + PRESC_W'(1);
    end
endmodule

// File: rtl/rtc_hms_alarm.sv
// hh:mm:ss timebase with validated load, hh:mm alarm (sticky irq) and 12-hour view.
module rtc_hms_alarm
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PRESC_W       = 26
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            load_valid,
    input  logic [HH_W-1:0] load_hh,
    input  logic [MS_W-1:0] load_mm,
    input  logic [MS_W-1:0] load_ss,
    output logic            load_err,
    input  logic            alarm_en,
    input  logic [HH_W-1:0] alarm_hh,
    input  logic [MS_W-1:0] alarm_mm,
    input  logic            alarm_ack,
    output logic            alarm_irq,
    output logic [HH_W-1:0] hh,
    output logic [MS_W-1:0] mm,
    output logic [MS_W-1:0] ss,
    output logic [3:0]      hh12,
    output logic            pm,
    output logic            sec_tick,
    output logic            day_tick
);
    rtc_time_t cur, nxt, ld, alm;
    logic      tick, load_ok, day_wrap, match;

    assign ld      = {load_hh, load_mm, load_ss};
    assign alm     = {alarm_hh, alarm_mm, 6'd0};
    assign load_ok = load_valid && time_legal(ld);

    rtc_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .PRESC_W      (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clear(load_ok),
        .tick (tick)
    );

    always_comb begin
        nxt      = cur;
        day_wrap = (cur.ss == MAX_MS) && (cur.mm == MAX_MS) && (cur.hh == MAX_HH);
        if (cur.ss != MAX_MS) begin
            nxt.ss = cur.ss + 6'd1;
        end else begin
            nxt.ss = '0;
            if (cur.mm != MAX_MS) begin
                nxt.mm = cur.mm + 6'd1;
            end else begin
                nxt.mm = '0;
                nxt.hh = (cur.hh == MAX_HH) ? '0 : cur.hh + 5'd1;
            end
        end
    end

    // Only a counted second can hit the alarm; a load that lands on it does not.
    assign match = tick && !load_ok && alarm_en && time_legal(alm) && (nxt == alm);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            sec_tick  <= 1'b0;
            day_tick  <= 1'b0;
            load_err  <= 1'b0;
            alarm_irq <= 1'b0;
        end else begin
            sec_tick <= tick && !load_ok;
            day_tick <= tick && !load_ok && day_wrap;
            load_err <= load_valid && !load_ok;
            if (load_ok)   cur <= ld;
            else if (tick) cur <= nxt;
            if (match)          alarm_irq <= 1'b1;
            else if (alarm_ack) alarm_irq <= 1'b0;
        end
    end

    assign hh = cur.hh;
    assign mm = cur.mm;
    assign ss = cur.ss;
    assign pm = (cur.hh >= 5'd12);

    always_comb begin
        hh12 = 4'(cur.hh);
        if (cur.hh == 5'd0)      hh12 = 4'd12;
        else if (cur.hh > 5'd12) hh12 = 4'(cur.hh - 5'd12);
    end
endmodule
